// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type, line geometry and address-split width helpers.
package dcache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, WRITE = 2'd2} state_t;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W = 2;
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int lines);
    return 32 - OFF_W - 2 - $clog2(lines);
  endfunction
endpackage

// File: rtl/dcache_data_array.sv
// dcache_data_array: LINES x 4 x 32 word storage, async read, one-word sync write, no reset.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic                    clk_i,
  input  logic                    we,
  input  logic [idx_w(LINES)-1:0] idx,
  input  logic [OFF_W-1:0]        woff,
  input  logic [31:0]             wdata,
  input  logic [OFF_W-1:0]        roff,
  output logic [31:0]             rdata
);
  logic [31:0] mem [LINES][WORDS_PER_LINE];
  assign rdata = mem[idx][roff];
  always_ff @(posedge clk_i)
    if (we) mem[idx][woff] <= wdata;
endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through no-write-allocate data cache with line refill.
// Optional DCACHE_STATS_EN adds saturating load hit/miss counters.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
`ifdef DCACHE_STATS_EN
  ,output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
`endif
);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES);
  state_t           state;
  logic [1:0]       cnt;
  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [IW-1:0]    index;
  logic [TW-1:0]    tag;
  logic [1:0]       offset;
  logic [31:0]      rdata;
  logic             hit, read_hit, read_miss, last_ack, we;
  assign offset    = addr_i[3:2];
  assign index     = addr_i[4 +: IW];
  assign tag       = addr_i[31 -: TW];
  assign hit       = valid[index] && tags[index] == tag;
  assign read_hit  = state == IDLE && MemRead_i && !MemWrite_i && hit;
  assign read_miss = state == IDLE && MemRead_i && !MemWrite_i && !hit;
  assign last_ack  = state == REFILL && mem_ack_i && cnt == 2'd3;
  // stall is masked during reset so every output sits at its reset value
  assign stall_o     = rst_i && ((state == IDLE && (MemRead_i || MemWrite_i) && !read_hit) ||
                                 state == REFILL || (state == WRITE && !mem_ack_i));
  assign data_o      = read_hit ? rdata : 32'd0;
  assign mem_read_o  = state == REFILL;
  assign mem_write_o = state == WRITE;
  assign mem_addr_o  = state == REFILL ? {addr_i[31:4], cnt, 2'b00} :
                       state == WRITE  ? (addr_i & ~32'h3) : 32'd0;
  assign mem_data_o  = state == WRITE ? data_i : 32'd0;
  assign we          = (state == REFILL && mem_ack_i) || (state == WRITE && mem_ack_i && hit);
  dcache_data_array #(.LINES(LINES)) u_data (
    .clk_i (clk_i),
    .we    (we),
    .idx   (index),
    .woff  (state == REFILL ? cnt : offset),
    .wdata (state == REFILL ? mem_data_i : data_i),
    .roff  (offset),
    .rdata (rdata)
  );
  // the line is invalidated on refill entry so a reset mid-refill leaves it invalid
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= 2'd0;
      valid <= '0;
    end else if (state == IDLE) begin
      if (MemWrite_i) state <= WRITE;
      else if (read_miss) begin
        state        <= REFILL;
        cnt          <= 2'd0;
        valid[index] <= 1'b0;
      end
    end else if (mem_ack_i) begin
      if (state == REFILL) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          valid[index] <= 1'b1;
          state        <= IDLE;
        end
      end else state <= IDLE;
    end
  always_ff @(posedge clk_i)
    if (last_ack) tags[index] <= tag;
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      hit_cnt_o  <= 16'd0;
      miss_cnt_o <= 16'd0;
    end else begin
      if (read_hit && hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
      if (read_miss && miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed checks of dcache_wt against a word memory with programmable wait states.
module tb_dcache_wt;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [31:0] data_o, mem_addr_o, mem_data_o, mem_data_i;
  logic        stall_o, mem_read_o, mem_write_o, mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_o, miss_cnt_o;
`endif
  int checks = 0, failures = 0;
  logic [31:0] mem [64];
  logic [31:0] rd_addr [256];
  logic [31:0] wr_addr [256];
  int n_rd = 0, n_wr = 0, wcnt = 0, wait_n = 0, unstable = 0;
  logic init_done = 1'b0, pend = 1'b0;
  logic [31:0] paddr = '0;

  dcache_wt #(.LINES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .data_o(data_o), .stall_o(stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(input int i);
    return (i >= 4 && i <= 7) ? 32'h11111111 * (i - 3) : (32'hC0DE0000 | i);
  endfunction

  assign mem_ack_i  = (mem_read_o || mem_write_o) && wcnt == wait_n;
  assign mem_data_i = mem[mem_addr_o[7:2]];

  always @(posedge clk_i) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end
    if (pend && (mem_read_o || mem_write_o) && mem_addr_o != paddr) unstable <= unstable + 1;
    pend  <= (mem_read_o || mem_write_o) && !mem_ack_i;
    paddr <= mem_addr_o;
    if (mem_ack_i) begin
      wcnt <= 0;
      if (mem_write_o) begin
        mem[mem_addr_o[7:2]] <= mem_data_o;
        wr_addr[n_wr] <= mem_addr_o;
        n_wr <= n_wr + 1;
      end
      if (mem_read_o) begin
        rd_addr[n_rd] <= mem_addr_o;
        n_rd <= n_rd + 1;
      end
    end else wcnt <= (mem_read_o || mem_write_o) ? wcnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int st, output logic [31:0] q);
    @(negedge clk_i);
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; data_i = d; st = 0;
    #1;
    while (stall_o && st < 200) begin
      st++;
      @(negedge clk_i);
      #1;
    end
    q = data_o;
    @(posedge clk_i);
    #1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, r0, w0;
    logic [31:0] q;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read_o}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_data", data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    // cold read miss
    r0 = n_rd; w0 = n_wr;
    access(1'b1, 1'b0, 32'h10, 32'h0, st, q);
    chk("cold_stall", st, 32'd5);
    chk("cold_data", q, 32'h11111111);
    chk("cold_nreads", n_rd - r0, 32'd4);
    chk("cold_rd0", rd_addr[r0], 32'h10);
    chk("cold_rd1", rd_addr[r0+1], 32'h14);
    chk("cold_rd2", rd_addr[r0+2], 32'h18);
    chk("cold_rd3", rd_addr[r0+3], 32'h1C);
    chk("cold_nwrites", n_wr - w0, 32'd0);
`ifdef DCACHE_STATS_EN
    chk("stats_miss", {16'd0, miss_cnt_o}, 32'd1);
    chk("stats_hit", {16'd0, hit_cnt_o}, 32'd1);
`endif
    access(1'b1, 1'b0, 32'h18, 32'h0, st, q);
    chk("hit18_stall", st, 32'd0);
    chk("hit18_data", q, 32'h33333333);
    // store miss: no allocate
    r0 = n_rd; w0 = n_wr;
    access(1'b0, 1'b1, 32'h20, 32'h12345678, st, q);
    chk("stmiss_stall", st, 32'd1);
    chk("stmiss_nwrites", n_wr - w0, 32'd1);
    chk("stmiss_waddr", wr_addr[w0], 32'h20);
    chk("stmiss_nreads", n_rd - r0, 32'd0);
    chk("stmiss_mem", mem[8], 32'h12345678);
    access(1'b1, 1'b0, 32'h20, 32'h0, st, q);
    chk("ld20_stall", st, 32'd5);
    chk("ld20_data", q, 32'h12345678);
    // store hit updates cache and memory
    w0 = n_wr;
    access(1'b0, 1'b1, 32'h14, 32'hA5A5A5A5, st, q);
    chk("sthit_stall", st, 32'd1);
    chk("sthit_waddr", wr_addr[w0], 32'h14);
    chk("sthit_mem", mem[5], 32'hA5A5A5A5);
    access(1'b1, 1'b0, 32'h14, 32'h0, st, q);
    chk("ld14_stall", st, 32'd0);
    chk("ld14_data", q, 32'hA5A5A5A5);
    // reset in the middle of a refill of line 1
    access(1'b1, 1'b0, 32'h50, 32'h0, st, q);
    chk("ld50_stall", st, 32'd5);
    @(negedge clk_i);
    addr_i = 32'h10; MemRead_i = 1'b1; r0 = n_rd;
    for (int i = 0; i < 50 && n_rd < r0 + 2; i++) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_mem_read", {31'd0, mem_read_o}, 32'd0);
    chk("midrst_mem_addr", mem_addr_o, 32'd0);
    chk("midrst_data", data_o, 32'd0);
    MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    // conflict: 0x10, 0x50, 0x10 all refill index 1
    r0 = n_rd;
    access(1'b1, 1'b0, 32'h10, 32'h0, st, q);
    chk("cf1_stall", st, 32'd5);
    chk("cf1_data", q, 32'h11111111);
    chk("cf1_nreads", n_rd - r0, 32'd4);
    chk("cf1_rd0", rd_addr[r0], 32'h10);
    access(1'b1, 1'b0, 32'h54, 32'h0, st, q);
    chk("cf2_stall", st, 32'd5);
    chk("cf2_data", q, 32'hC0DE0015);
    access(1'b1, 1'b0, 32'h1C, 32'h0, st, q);
    chk("cf3_stall", st, 32'd5);
    chk("cf3_data", q, 32'h44444444);
    chk("cf_nreads", n_rd - r0, 32'd12);
    // three wait cycles per word
    wait_n = 3;
    access(1'b1, 1'b0, 32'h38, 32'h0, st, q);
    chk("wait_stall", st, 32'd17);
    chk("wait_data", q, 32'hC0DE000E);
    chk("wait_addr_stable", unstable, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
